// File: rtl/sum_checker_pkg.sv
// sum_checker_pkg: shared state encoding and default pipeline latency
package sum_checker_pkg;
  localparam int LATENCY_DEF = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;
endpackage

// File: rtl/sum_checker_delay.sv
// sum_checker_delay: resettable W-bit shift register, D stages deep
module sum_checker_delay #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  // shift one stage per cycle; reset flushes every stage
  always_ff @(posedge clk) begin
    if (reset) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[D-1];
endmodule

// File: rtl/sum_checker.sv
// sum_checker: compares two adder pipelines against a delayed reference sum/index
module sum_checker
  import sum_checker_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       dataA,
  input  logic [3:0]       dataB,
  input  logic [3:0]       sum30_dd,
  input  logic [3:0]       idx_dd,
  input  logic [3:0]       sum30_dd_estruct,
  input  logic [3:0]       idx_dd_estruct,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_pulse,
  output logic             fail,
  output logic [1:0]       state
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [3:0] idx, exp_sum, d_idx, d_sum;
  logic       dv, bad;
  state_t     st, st_nx;
  assign exp_sum = dataA + dataB;
  // sample index advances only on valid samples, wrapping naturally at 4 bits
  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else if (valid_in) idx <= idx + 4'd1;
  end
  sum_checker_delay #(.W(9), .D(LATENCY)) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    ({valid_in, idx, exp_sum}),
    .q    ({dv, d_idx, d_sum})
  );
  assign bad = dv && (sum30_dd != d_sum || sum30_dd_estruct != d_sum ||
                      idx_dd != d_idx || idx_dd_estruct != d_idx);
  // state register
  always_ff @(posedge clk) begin
    st <= reset ? ST_IDLE : st_nx;
  end
  // next state: any failed check lands in FAIL, which only reset leaves
  always_comb begin
    st_nx = (st == ST_FAIL || bad)    ? ST_FAIL  :
            (st == ST_IDLE && valid_in) ? ST_FILL  :
            (st == ST_FILL && dv)       ? ST_CHECK : st;
  end
  // state-derived outputs
  always_comb begin
    fail  = st == ST_FAIL;
    state = st;
  end
  // saturating result counters and the per-check error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (dv && !bad && match_cnt != CMAX) match_cnt <= match_cnt + 1'b1;
      if (bad && mismatch_cnt != CMAX) mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_checker.sv
// tb_sum_checker: directed-vector bench for sum_checker
module tb_sum_checker;
  localparam int LAT = 2;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
  logic [3:0] dataA = '0, dataB = '0;
  logic [3:0] sum30_dd = '0, idx_dd = '0, sum30_dd_estruct = '0, idx_dd_estruct = '0;
  logic [7:0] match_cnt, mismatch_cnt;
  logic [1:0] m2_cnt, mm2_cnt;
  logic err_pulse, fail, err2, fail2;
  logic [1:0] state, state2;
  int total = 0, nbad = 0;
  int cyc, nchk, corrupt_at, n_err, err_cyc;
  bit corrupt_all;
  logic [3:0] bidx;
  logic       hv [256];
  logic [3:0] hs [256], hi [256];

  always #5 clk = ~clk;

  sum_checker #(.LATENCY(LAT), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .dataA(dataA), .dataB(dataB),
    .sum30_dd(sum30_dd), .idx_dd(idx_dd), .sum30_dd_estruct(sum30_dd_estruct),
    .idx_dd_estruct(idx_dd_estruct), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .err_pulse(err_pulse), .fail(fail), .state(state));

  sum_checker #(.LATENCY(LAT), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .dataA(dataA), .dataB(dataB),
    .sum30_dd(sum30_dd), .idx_dd(idx_dd), .sum30_dd_estruct(sum30_dd_estruct),
    .idx_dd_estruct(idx_dd_estruct), .match_cnt(m2_cnt), .mismatch_cnt(mm2_cnt),
    .err_pulse(err2), .fail(fail2), .state(state2));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one cycle: apply a sample and emulate both pipelines LAT cycles later
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    valid_in = v; dataA = a; dataB = b;
    hv[cyc] = v; hs[cyc] = a + b; hi[cyc] = bidx;
    if (v) bidx = bidx + 4'd1;
    if (cyc >= LAT && hv[cyc-LAT]) begin
      nchk++;
      sum30_dd = hs[cyc-LAT];
      idx_dd = hi[cyc-LAT];
      idx_dd_estruct = hi[cyc-LAT];
      sum30_dd_estruct = (corrupt_all || nchk == corrupt_at) ? 4'd0 : hs[cyc-LAT];
    end else begin
      sum30_dd = '0; idx_dd = '0; sum30_dd_estruct = '0; idx_dd_estruct = '0;
    end
    @(negedge clk);
    if (err_pulse) begin n_err++; err_cyc = cyc; end
    cyc++;
  endtask

  task automatic rst_dut(input string tag);
    reset = 1'b1; valid_in = 1'b0; dataA = '0; dataB = '0;
    sum30_dd = '0; idx_dd = '0; sum30_dd_estruct = '0; idx_dd_estruct = '0;
    @(negedge clk); @(negedge clk);
    check({tag, "_rst_match"}, match_cnt, 0);
    check({tag, "_rst_mismatch"}, mismatch_cnt, 0);
    check({tag, "_rst_err"}, err_pulse, 0);
    check({tag, "_rst_fail"}, fail, 0);
    check({tag, "_rst_state"}, state, 0);
    reset = 1'b0;
    cyc = 0; nchk = 0; bidx = '0; corrupt_at = 0; corrupt_all = 0; n_err = 0; err_cyc = -1;
  endtask

  task automatic flush();
    repeat (LAT) drive(1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    logic [4:0] pat;
    @(negedge clk);
    // all-correct stream
    rst_dut("t1");
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i), 4'(15 - i));
      if (i == 0) check("t1_fill", state, 1);
    end
    flush();
    check("t1_match", match_cnt, 7);
    check("t1_mismatch", mismatch_cnt, 0);
    check("t1_fail", fail, 0);
    check("t1_state", state, 2);
    // structural sum forced to 0 on the 3rd check
    rst_dut("t2");
    corrupt_at = 3;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i), 4'(15 - i));
      if (i == 4) begin
        check("t2_err_hi", err_pulse, 1);
        check("t2_mm_at_err", mismatch_cnt, 1);
        check("t2_state_at_err", state, 3);
      end
      if (i == 5) check("t2_err_lo", err_pulse, 0);
    end
    flush();
    check("t2_match", match_cnt, 6);
    check("t2_mismatch", mismatch_cnt, 1);
    check("t2_fail", fail, 1);
    check("t2_state", state, 3);
    check("t2_err_count", n_err, 1);
    check("t2_err_cycle", err_cyc, 4);
    // 18 samples: index wraps 15 -> 0 -> 1
    rst_dut("t3");
    repeat (18) drive(1'b1, 4'd1, 4'd1);
    flush();
    check("t3_match", match_cnt, 18);
    check("t3_mismatch", mismatch_cnt, 0);
    check("t3_state", state, 2);
    // gapped valid: 1,0,1,0,1
    rst_dut("t4");
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      drive(pat[i], 4'(i), 4'd1);
      if (i == 2) check("t4_match_c2", match_cnt, 1);
      if (i == 3) check("t4_match_c3", match_cnt, 1);
    end
    flush();
    check("t4_checks", nchk, 3);
    check("t4_match", match_cnt, 3);
    check("t4_mismatch", mismatch_cnt, 0);
    // reset mid-stream discards in-flight samples
    rst_dut("t5");
    drive(1'b1, 4'd3, 4'd4);
    drive(1'b1, 4'd5, 4'd6);
    drive(1'b0, 4'd0, 4'd0);
    check("t5_pre_match", match_cnt, 1);
    rst_dut("t5b");
    repeat (LAT + 1) drive(1'b0, 4'd0, 4'd0);
    check("t5_match", match_cnt, 0);
    check("t5_mismatch", mismatch_cnt, 0);
    check("t5_err_count", n_err, 0);
    check("t5_state", state, 0);
    // 5 failing samples saturate the 2-bit counter
    rst_dut("t6");
    corrupt_all = 1;
    repeat (5) drive(1'b1, 4'd1, 4'd1);
    flush();
    check("t6_mm2_sat", mm2_cnt, 3);
    check("t6_m2", m2_cnt, 0);
    check("t6_state2", state2, 3);
    check("t6_mm8", mismatch_cnt, 5);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
